// File: rtl/native2axil.sv
// Native strobe request -> AXI4-Lite master bridge, one transaction in flight.
// Define NATIVE2AXIL_TIMEOUT_EN to build the hung-slave watchdog (TIMEOUT_CYCLES).
module native2axil #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    AXI_ACLK,
  input  logic                    AXI_ARESETN,

  output logic                    REQ_READY,
  input  logic                    WEN,
  input  logic [ADDR_WIDTH-1:0]   WADDR,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  output logic                    WACK,
  output logic [1:0]              WRESP,
  input  logic                    REN,
  input  logic [ADDR_WIDTH-1:0]   RADDR,
  output logic                    RVALID,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,

  output logic [ADDR_WIDTH-1:0]   AXI_AWADDR,
  output logic [2:0]              AXI_AWPROT,
  output logic                    AXI_AWVALID,
  input  logic                    AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]   AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0] AXI_WSTRB,
  output logic                    AXI_WVALID,
  input  logic                    AXI_WREADY,
  input  logic [1:0]              AXI_BRESP,
  input  logic                    AXI_BVALID,
  output logic                    AXI_BREADY,
  output logic [ADDR_WIDTH-1:0]   AXI_ARADDR,
  output logic [2:0]              AXI_ARPROT,
  output logic                    AXI_ARVALID,
  input  logic                    AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0]   AXI_RDATA,
  input  logic [1:0]              AXI_RRESP,
  input  logic                    AXI_RVALID,
  output logic                    AXI_RREADY
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_ADDR,
    RD_DATA
  } state_t;

  state_t state, state_next;

  logic                  aw_done, w_done;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;
  logic                  wack_q, rvalid_q;
  logic [1:0]            wresp_q, rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic timeout;

  // Bus controls decode straight from registered state so a reset drops them at once.
  assign REQ_READY   = (state == IDLE);
  assign AXI_AWVALID = (state == WR_REQ) && !aw_done;
  assign AXI_WVALID  = (state == WR_REQ) && !w_done;
  assign AXI_BREADY  = (state == WR_RESP);
  assign AXI_ARVALID = (state == RD_ADDR);
  assign AXI_RREADY  = (state == RD_DATA);

  assign AXI_AWADDR = addr_q;
  assign AXI_ARADDR = addr_q;
  assign AXI_WDATA  = wdata_q;
  assign AXI_WSTRB  = wstrb_q;
  assign AXI_AWPROT = 3'b000;
  assign AXI_ARPROT = 3'b000;

  assign WACK   = wack_q;
  assign WRESP  = wresp_q;
  assign RVALID = rvalid_q;
  assign RDATA  = rdata_q;
  assign RRESP  = rresp_q;

  assign aw_hs = AXI_AWVALID && AXI_AWREADY;
  assign w_hs  = AXI_WVALID  && AXI_WREADY;
  assign b_hs  = AXI_BVALID  && AXI_BREADY;
  assign ar_hs = AXI_ARVALID && AXI_ARREADY;
  assign r_hs  = AXI_RVALID  && AXI_RREADY;

`ifdef NATIVE2AXIL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt;

  // Firing on the last counted cycle leaves the VALID up for exactly TIMEOUT_CYCLES cycles.
  assign timeout = (state != IDLE) && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      tmo_cnt <= '0;
    end else if (state == IDLE) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + CNT_W'(1);
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (WEN) begin
          state_next = WR_REQ;
        end else if (REN) begin
          state_next = RD_ADDR;
        end
      end
      WR_REQ: begin
        if ((aw_done || aw_hs) && (w_done || w_hs)) begin
          state_next = WR_RESP;
        end
      end
      WR_RESP: begin
        if (b_hs) begin
          state_next = IDLE;
        end
      end
      RD_ADDR: begin
        if (ar_hs) begin
          state_next = RD_DATA;
        end
      end
      RD_DATA: begin
        if (r_hs) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (timeout) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      wack_q   <= 1'b0;
      wresp_q  <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= '0;
    end else begin
      wack_q   <= 1'b0;
      rvalid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (WEN) begin
            addr_q  <= WADDR;
            wdata_q <= WDATA;
            wstrb_q <= WSTRB;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end else if (REN) begin
            addr_q <= RADDR;
          end
        end
        WR_REQ: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
        end
        WR_RESP: begin
          if (b_hs) begin
            wack_q  <= 1'b1;
            wresp_q <= AXI_BRESP;
          end
        end
        RD_DATA: begin
          if (r_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= AXI_RDATA;
            rresp_q  <= AXI_RRESP;
          end
        end
        default: ;
      endcase
      // Watchdog completion overrides any same-cycle bus response.
      if (timeout) begin
        if (state == WR_REQ || state == WR_RESP) begin
          wack_q  <= 1'b1;
          wresp_q <= 2'b11;
        end else begin
          rvalid_q <= 1'b1;
          rresp_q  <= 2'b11;
          rdata_q  <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_native2axil.sv
// Bench for native2axil: delay-programmable AXI4-Lite slave, vector table,
// hand-written corner sequences and a randomized run against a memory model.
module tb_native2axil;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_ready, wen, ren, wack, rvalid;
  logic [31:0] waddr, wdata, raddr, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  wresp, rresp;

  logic [31:0] a_awaddr, a_wdata, a_araddr, a_rdata;
  logic [2:0]  a_awprot, a_arprot;
  logic [3:0]  a_wstrb;
  logic        a_awvalid, a_awready, a_wvalid, a_wready, a_bvalid, a_bready;
  logic        a_arvalid, a_arready, a_rvalid, a_rready;
  logic [1:0]  a_bresp, a_rresp;

  native2axil #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .AXI_ACLK(clk), .AXI_ARESETN(rst_n),
    .REQ_READY(req_ready), .WEN(wen), .WADDR(waddr), .WDATA(wdata), .WSTRB(wstrb),
    .WACK(wack), .WRESP(wresp), .REN(ren), .RADDR(raddr),
    .RVALID(rvalid), .RDATA(rdata), .RRESP(rresp),
    .AXI_AWADDR(a_awaddr), .AXI_AWPROT(a_awprot), .AXI_AWVALID(a_awvalid), .AXI_AWREADY(a_awready),
    .AXI_WDATA(a_wdata), .AXI_WSTRB(a_wstrb), .AXI_WVALID(a_wvalid), .AXI_WREADY(a_wready),
    .AXI_BRESP(a_bresp), .AXI_BVALID(a_bvalid), .AXI_BREADY(a_bready),
    .AXI_ARADDR(a_araddr), .AXI_ARPROT(a_arprot), .AXI_ARVALID(a_arvalid), .AXI_ARREADY(a_arready),
    .AXI_RDATA(a_rdata), .AXI_RRESP(a_rresp), .AXI_RVALID(a_rvalid), .AXI_RREADY(a_rready)
  );

  always #5 clk = ~clk;

  // ---------------- AXI4-Lite slave with programmable wait states ----------------
  int aw_d = 0, w_d = 0, b_d = 0, ar_d = 0, r_d = 0;
  logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  bit [31:0] slave_mem [64];
  int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  logic aw_got, w_got, b_busy, r_busy;
  logic [31:0] aw_addr_s, w_data_s;
  logic [3:0]  w_strb_s;
  logic s_aw_hs, s_w_hs, s_a_now, s_w_now;
  logic [31:0] s_wr_addr, s_wr_data;
  logic [3:0]  s_wr_strb;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  assign a_awready = a_awvalid && (aw_cnt >= aw_d);
  assign a_wready  = a_wvalid  && (w_cnt  >= w_d);
  assign a_arready = a_arvalid && (ar_cnt >= ar_d);
  assign s_aw_hs   = a_awvalid && a_awready;
  assign s_w_hs    = a_wvalid  && a_wready;
  assign s_a_now   = aw_got || s_aw_hs;
  assign s_w_now   = w_got  || s_w_hs;
  assign s_wr_addr = aw_got ? aw_addr_s : a_awaddr;
  assign s_wr_data = w_got  ? w_data_s  : a_wdata;
  assign s_wr_strb = w_got  ? w_strb_s  : a_wstrb;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
      aw_got <= 0; w_got <= 0; b_busy <= 0; r_busy <= 0;
      a_bvalid <= 0; a_rvalid <= 0; a_bresp <= 0; a_rresp <= 0; a_rdata <= 0;
      aw_addr_s <= 0; w_data_s <= 0; w_strb_s <= 0;
    end else begin
      aw_cnt <= (a_awvalid && !a_awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (a_wvalid  && !a_wready)  ? w_cnt  + 1 : 0;
      ar_cnt <= (a_arvalid && !a_arready) ? ar_cnt + 1 : 0;
      if (s_aw_hs) begin aw_got <= 1; aw_addr_s <= a_awaddr; end
      if (s_w_hs)  begin w_got <= 1; w_data_s <= a_wdata; w_strb_s <= a_wstrb; end
      if (s_a_now && s_w_now && !b_busy) begin
        slave_mem[s_wr_addr[7:2]] <= merge(slave_mem[s_wr_addr[7:2]], s_wr_data, s_wr_strb);
        aw_got <= 0; w_got <= 0; b_busy <= 1; b_cnt <= b_d;
        a_bvalid <= (b_d == 0); a_bresp <= bresp_cfg;
      end else if (b_busy && !a_bvalid) begin
        if (b_cnt <= 1) a_bvalid <= 1;
        b_cnt <= b_cnt - 1;
      end
      if (a_bvalid && a_bready) begin a_bvalid <= 0; b_busy <= 0; end
      if (a_arvalid && a_arready) begin
        r_busy <= 1; r_cnt <= r_d; a_rvalid <= (r_d == 0);
        a_rdata <= slave_mem[a_araddr[7:2]]; a_rresp <= rresp_cfg;
      end else if (r_busy && !a_rvalid) begin
        if (r_cnt <= 1) a_rvalid <= 1;
        r_cnt <= r_cnt - 1;
      end
      if (a_rvalid && a_rready) begin a_rvalid <= 0; r_busy <= 0; end
    end
  end

  // ---------------- bus monitor: cycle counters and stability ----------------
  int aw_cyc = 0, w_cyc = 0, ar_cyc = 0, b_hs_n = 0, wack_n = 0, rv_n = 0, stab_err = 0;
  logic prev_awv = 0, prev_wv = 0, prev_arv = 0;
  logic [31:0] prev_awaddr = 0, prev_wdata = 0, prev_araddr = 0;
  logic [3:0]  prev_wstrb = 0;

  always @(negedge clk) begin
    if (a_awvalid) aw_cyc <= aw_cyc + 1;
    if (a_wvalid)  w_cyc  <= w_cyc + 1;
    if (a_arvalid) ar_cyc <= ar_cyc + 1;
    if (a_bvalid && a_bready) b_hs_n <= b_hs_n + 1;
    if (wack)   wack_n <= wack_n + 1;
    if (rvalid) rv_n   <= rv_n + 1;
    if ((prev_awv && a_awvalid && a_awaddr != prev_awaddr) ||
        (prev_wv && a_wvalid && (a_wdata != prev_wdata || a_wstrb != prev_wstrb)) ||
        (prev_arv && a_arvalid && a_araddr != prev_araddr))
      stab_err <= stab_err + 1;
    prev_awv <= a_awvalid; prev_awaddr <= a_awaddr;
    prev_wv <= a_wvalid; prev_wdata <= a_wdata; prev_wstrb <= a_wstrb;
    prev_arv <= a_arvalid; prev_araddr <= a_araddr;
  end

  // ---------------- checking helpers and reference model ----------------
  int n_vec = 0, n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  bit [31:0] ref_mem [int unsigned];

  function automatic bit [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bit [31:0] v;
    v = ref_read(a);
    for (int b = 0; b < 4; b++) if (s[b]) v[8*b +: 8] = d[8*b +: 8];
    ref_mem[a] = v;
  endtask

  int s_aw, s_w, s_ar, s_b, s_wk, s_rv;
  task automatic snap();
    s_aw = aw_cyc; s_w = w_cyc; s_ar = ar_cyc; s_b = b_hs_n; s_wk = wack_n; s_rv = rv_n;
  endtask

  // Called just after a negedge; returns one negedge after the completion pulse.
  task automatic run_txn(input bit wr, input bit also_ren, input logic [31:0] addr,
                         input logic [31:0] d, input logic [3:0] s,
                         output int lat, output logic [1:0] resp, output logic [31:0] rd);
    int t;
    lat = -1; resp = 2'bxx; rd = 'x;
    t = 0;
    while (!req_ready && t < 200) begin @(negedge clk); t++; end
    if (wr) begin
      wen = 1; waddr = addr; wdata = d; wstrb = s;
      ren = also_ren; raddr = addr ^ 32'h4;
    end else begin
      ren = 1; raddr = addr;
    end
    @(negedge clk);
    wen = 0; ren = 0;
    for (int k = 1; k <= 400; k++) begin
      if (wr ? wack : rvalid) begin
        lat = k; resp = wr ? wresp : rresp; rd = rdata;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          awd, wd, bd, ard, rd;
    logic [1:0]  resp;
    int          exp_lat;
    int          exp_awv, exp_wv, exp_arv;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t        vt [7];
  int          lat, t;
  logic [1:0]  got_resp;
  logic [31:0] got_rd, last_rd, r_addr, r_data;
  logic [3:0]  r_strb;
  bit          r_wr, r_ren;
  int          ra, rw, rb, rar, rr, exp_lat;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    vt[0] = '{1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 0, 2'b00, 3, 1, 1, 0, 32'h0};
    vt[1] = '{1, 32'h14, 32'hCAFE_F00D, 4'hF, 3, 0, 0, 0, 0, 2'b00, 6, 4, 1, 0, 32'h0};
    vt[2] = '{1, 32'h20, 32'h1234_5678, 4'hF, 0, 2, 1, 0, 0, 2'b01, 6, 1, 3, 0, 32'h0};
    vt[3] = '{0, 32'h20, 32'h0,         4'h0, 0, 0, 0, 0, 5, 2'b10, 8, 0, 0, 1, 32'h1234_5678};
    vt[4] = '{0, 32'h10, 32'h0,         4'h0, 0, 0, 0, 2, 0, 2'b00, 5, 0, 0, 3, 32'hDEAD_BEEF};
    vt[5] = '{1, 32'h10, 32'hAABB_CCDD, 4'h5, 1, 1, 0, 0, 0, 2'b11, 4, 2, 2, 0, 32'h0};
    vt[6] = '{0, 32'h10, 32'h0,         4'h0, 0, 0, 0, 0, 1, 2'b00, 4, 0, 0, 1, 32'hDEBB_BEDD};

    wen = 0; ren = 0; waddr = 0; wdata = 0; wstrb = 0; raddr = 0;
    repeat (3) @(negedge clk);
    chk("reset_req_ready", req_ready, 1);
    chk("reset_valids", {a_awvalid, a_wvalid, a_bready, a_arvalid, a_rready, wack, rvalid}, 0);
    chk("reset_native_out", {rdata, wresp, rresp}, 0);
    chk("prot", {a_awprot, a_arprot}, 0);
    rst_n = 1;
    @(negedge clk);
    last_rd = 32'h0;

    // ---- table-driven vectors ----
    foreach (vt[i]) begin
      aw_d = vt[i].awd; w_d = vt[i].wd; b_d = vt[i].bd; ar_d = vt[i].ard; r_d = vt[i].rd;
      bresp_cfg = vt[i].resp; rresp_cfg = vt[i].resp;
      snap();
      run_txn(vt[i].wr, 0, vt[i].addr, vt[i].data, vt[i].strb, lat, got_resp, got_rd);
      if (vt[i].wr) ref_write(vt[i].addr, vt[i].data, vt[i].strb);
      else last_rd = vt[i].exp_rdata;
      chk($sformatf("vec%0d_latency", i), lat, vt[i].exp_lat);
      chk($sformatf("vec%0d_resp", i), got_resp, vt[i].resp);
      chk($sformatf("vec%0d_rdata", i), got_rd, last_rd);
      chk($sformatf("vec%0d_awvalid_cycles", i), aw_cyc - s_aw, vt[i].exp_awv);
      chk($sformatf("vec%0d_wvalid_cycles", i), w_cyc - s_w, vt[i].exp_wv);
      chk($sformatf("vec%0d_arvalid_cycles", i), ar_cyc - s_ar, vt[i].exp_arv);
      chk($sformatf("vec%0d_pulses", i), {wack_n - s_wk, rv_n - s_rv},
          vt[i].wr ? {32'd1, 32'd0} : {32'd0, 32'd1});
    end
    aw_d = 0; w_d = 0; b_d = 0; ar_d = 0; r_d = 0; bresp_cfg = 0; rresp_cfg = 0;

    // ---- WEN and REN together, then REN while busy ----
    snap();
    aw_d = 2;
    wen = 1; ren = 1; waddr = 32'h30; wdata = 32'h5A5A_5A5A; wstrb = 4'hF; raddr = 32'h10;
    @(negedge clk);
    wen = 0; ren = 1; raddr = 32'h14;
    chk("busy_req_ready", req_ready, 0);
    @(negedge clk);
    ren = 0;
    t = 0;
    while (!wack && t < 50) begin @(negedge clk); t++; end
    repeat (6) @(negedge clk);
    ref_write(32'h30, 32'h5A5A_5A5A, 4'hF);
    chk("prio_arvalid_cycles", ar_cyc - s_ar, 0);
    chk("prio_rvalid_pulses", rv_n - s_rv, 0);
    chk("prio_wack_pulses", wack_n - s_wk, 1);
    chk("prio_b_handshakes", b_hs_n - s_b, 1);
    aw_d = 0;
    run_txn(0, 0, 32'h30, 0, 0, lat, got_resp, got_rd);
    last_rd = 32'h5A5A_5A5A;
    chk("prio_readback", got_rd, last_rd);

    // ---- reset while AWVALID is high ----
    snap();
    aw_d = 8; w_d = 8;
    wen = 1; waddr = 32'h18; wdata = 32'h7777_7777; wstrb = 4'hF;
    @(negedge clk);
    wen = 0;
    chk("pre_reset_awvalid", a_awvalid, 1);
    rst_n = 0;
    #1;
    chk("async_reset_valids", {a_awvalid, a_wvalid}, 0);
    chk("async_reset_req_ready", req_ready, 1);
    @(negedge clk); @(negedge clk);
    rst_n = 1; aw_d = 0; w_d = 0;
    repeat (3) @(negedge clk);
    chk("reset_no_wack", wack_n - s_wk, 0);
    chk("reset_rdata_cleared", rdata, 0);
    last_rd = 32'h0;
    snap();
    run_txn(1, 0, 32'h18, 32'h0BAD_F00D, 4'hF, lat, got_resp, got_rd);
    ref_write(32'h18, 32'h0BAD_F00D, 4'hF);
    chk("post_reset_write_latency", lat, 3);
    chk("post_reset_write_pulses", wack_n - s_wk, 1);
    run_txn(0, 0, 32'h18, 0, 0, lat, got_resp, got_rd);
    last_rd = ref_read(32'h18);
    chk("post_reset_readback", got_rd, last_rd);

`ifdef NATIVE2AXIL_TIMEOUT_EN
    // ---- watchdog: slave never raises ARREADY ----
    snap();
    ar_d = 100000;
    run_txn(0, 0, 32'h24, 0, 0, lat, got_resp, got_rd);
    chk("timeout_latency", lat, 17);
    chk("timeout_arvalid_cycles", ar_cyc - s_ar, 16);
    chk("timeout_rresp", got_resp, 2'b11);
    chk("timeout_rdata", got_rd, 0);
    last_rd = 32'h0;
    ar_d = 0;
    run_txn(0, 0, 32'h10, 0, 0, lat, got_resp, got_rd);
    last_rd = ref_read(32'h10);
    chk("timeout_recovery_read", got_rd, last_rd);
`endif

    // ---- randomized traffic against the memory model ----
    for (int i = 0; i < 60; i++) begin
      r_wr = 1'($urandom_range(0, 1));
      r_ren = 1'($urandom_range(0, 1));
      r_addr = 32'($urandom_range(0, 15)) << 2;
      r_data = $urandom;
      r_strb = 4'($urandom_range(0, 15));
      ra = $urandom_range(0, 3); rw = $urandom_range(0, 3); rb = $urandom_range(0, 3);
      rar = $urandom_range(0, 3); rr = $urandom_range(0, 3);
      aw_d = ra; w_d = rw; b_d = rb; ar_d = rar; r_d = rr;
      bresp_cfg = 2'($urandom_range(0, 3)); rresp_cfg = 2'($urandom_range(0, 3));
      exp_lat = r_wr ? 3 + ((ra > rw) ? ra : rw) + rb : 3 + rar + rr;
      snap();
      run_txn(r_wr, r_ren, r_addr, r_data, r_strb, lat, got_resp, got_rd);
      if (r_wr) ref_write(r_addr, r_data, r_strb);
      else last_rd = ref_read(r_addr);
      chk($sformatf("rnd%0d_latency", i), lat, exp_lat);
      chk($sformatf("rnd%0d_resp", i), got_resp, r_wr ? bresp_cfg : rresp_cfg);
      chk($sformatf("rnd%0d_rdata", i), got_rd, last_rd);
      chk($sformatf("rnd%0d_channels", i), {ar_cyc - s_ar == 0, aw_cyc - s_aw == 0},
          r_wr ? 2'b10 : 2'b01);
    end

    chk("axi_stability", stab_err, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/native2axil.md
Name: native2axil

Overview:
- Native-to-AXI4-Lite master bridge: the initiator counterpart of the AXI4-Lite-to-native slave bridge.
- Accepts single-beat register read/write requests on a simple native strobe interface and issues them as AXI4-Lite master transactions.
- One transaction in flight at a time; completion and response are reported back as native pulses.
- Sits between local control logic (sequencers, test drivers) and the AXI4-Lite interconnect.

Parameters:
- DATA_WIDTH, 32, AXI/native data width (multiple of 8).
- ADDR_WIDTH, 32, AXI/native address width.
- TIMEOUT_CYCLES, 256, watchdog limit per transaction; used only with the optional feature.

Ports:
- AXI_ACLK  in  1  single clock.
- AXI_ARESETN  in  1  reset; asynchronous assert, active-low.
- REQ_READY  out  1  bridge idle; a request is accepted when WEN or REN is high in the same cycle.
- WEN  in  1  write request strobe.
- WADDR  in  ADDR_WIDTH  write address.
- WDATA  in  DATA_WIDTH  write data.
- WSTRB  in  DATA_WIDTH/8  write byte strobes.
- WACK  out  1  one-cycle write completion pulse.
- WRESP  out  2  write response, valid with WACK.
- REN  in  1  read request strobe.
- RADDR  in  ADDR_WIDTH  read address.
- RVALID  out  1  one-cycle read completion pulse.
- RDATA  out  DATA_WIDTH  read data, valid with RVALID.
- RRESP  out  2  read response, valid with RVALID.
- AXI_AW*, AXI_W*, AXI_B*, AXI_AR*, AXI_R*  standard AXI4-Lite master signals; same widths as the slave bridge, directions inverted.

Behaviour:
- Reset (asynchronous, AXI_ARESETN=0):
  - State IDLE; REQ_READY=1.
  - All AXI VALID/READY outputs 0; WACK=0, RVALID=0.
  - WRESP=RRESP=0, RDATA=0, address/data registers 0.
  - Reset mid-transaction drops all VALIDs immediately, with no completion pulse.
- Constant outputs: AXI_AWPROT=AXI_ARPROT=3'b000.
- States: IDLE, WR_REQ, WR_RESP, RD_ADDR, RD_DATA.
- IDLE, WEN=1:
  - Register WADDR/WDATA/WSTRB, go to WR_REQ.
  - WEN has priority when WEN and REN are both high; that REN is dropped, not queued.
- IDLE, REN=1 (WEN=0): register RADDR, go to RD_ADDR.
- Requests while REQ_READY=0 are ignored.
- WR_REQ:
  - AWVALID and WVALID both asserted from the cycle after acceptance.
  - Each is deasserted independently the cycle after its own READY is sampled high; aw_done/w_done flags track this.
  - Both handshakes in the same cycle are legal.
  - When both are done, go to WR_RESP with BREADY=1.
- WR_RESP:
  - On BVALID&&BREADY: capture BRESP to WRESP, pulse WACK next cycle, deassert BREADY, go to IDLE.
- RD_ADDR: ARVALID=1 until ARREADY is sampled, then go to RD_DATA with RREADY=1.
- RD_DATA:
  - On AXI_RVALID&&RREADY: capture RDATA/RRESP, pulse native RVALID next cycle, go to IDLE.
- Back-to-back: REQ_READY is 1 in the cycle WACK/RVALID pulses, so a new request may be accepted in that cycle.
- AXI address/data/strobe outputs stay stable while the corresponding VALID is high.
- Minimum latency with a zero-wait slave:
  - Write: acceptance to WACK = 3 cycles.
  - Read: acceptance to RVALID = 3 cycles.
- No dependency on slave READY before VALID is asserted (AXI rule).
- WRESP/RRESP/RDATA hold their last value until the next completion.

Optional Feature:
- Macro: NATIVE2AXIL_TIMEOUT_EN.
- When defined:
  - A counter runs in every non-IDLE state and resets on entry to WR_REQ/RD_ADDR.
  - When it reaches TIMEOUT_CYCLES, all AXI VALID/READY outputs are forced to 0.
  - The native completion (WACK or RVALID) pulses with response 2'b11 and RDATA=0, and the state returns to IDLE.
  - This recovery path is for debug against hung slaves only and is a known protocol violation.
- When not defined: no counter is built, TIMEOUT_CYCLES is unused, and the bridge waits indefinitely.

Test Plan:
- Write 0x0000_0010 <= 0xDEAD_BEEF, WSTRB=0xF, zero-wait slave:
  - Single AW/W handshake with matching fields; WACK 3 cycles after acceptance; WRESP=0.
- Write with AWREADY delayed 4 cycles and WREADY immediate:
  - WVALID drops after 1 cycle, AWVALID holds 4 cycles; one B handshake; WACK once.
- Read 0x0000_0020, slave returns 0x1234_5678 with RRESP=2'b10 after 5 wait cycles:
  - RVALID pulse; RDATA=0x1234_5678; RRESP=2'b10.
- WEN and REN high together in IDLE:
  - Only the write is issued; ARVALID never asserts; a REN pulse while busy is ignored.
- Reset asserted while AWVALID=1:
  - AWVALID=0 immediately (asynchronously), no WACK; the next write after reset completes normally.
- With NATIVE2AXIL_TIMEOUT_EN, TIMEOUT_CYCLES=16, read to a slave that never raises ARREADY:
  - ARVALID drops after 16 cycles; RVALID pulses with RRESP=2'b11, RDATA=0.
